// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined two-level carry-lookahead adder/subtractor.
// WIDTH bits split into GROUP-bit lookahead groups; a second lookahead level
// over group generate/propagate produces every group carry-in directly, so no
// carry ripples between groups. A global advance signal moves all stages
// together, which gives a fixed latency of STAGES cycles plus stall cycles.
// With STAGES >= 2 the first register sits between the bit/group terms and
// the second-level lookahead; later registers carry finished results.

module cla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  localparam int NG = WIDTH / GROUP;
  // Intermediate word: {bb_msb, a_msb, ci, grp_p, grp_g, p, g, half_sum}
  localparam int MW = 3 * WIDTH + 2 * NG + 3;
  // Result word: {ovf, cout, y}
  localparam int RW = WIDTH + 2;

  // First level: operand conditioning, per-bit g/p and group G/P.
  function automatic logic [MW-1:0] front_end(input logic [WIDTH-1:0] av,
                                              input logic [WIDTH-1:0] bv,
                                              input logic             cv,
                                              input logic             sv);
    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] hs;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic             ci;
    logic             term;
    bb = sv ? ~bv : bv;
    ci = sv ? ~cv : cv;
    g  = av & bb;
    p  = av | bb;
    hs = av ^ bb;
    for (int k = 0; k < NG; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int j = 0; j < GROUP; j++) begin
        // generate at bit j, propagated through every higher bit of the group
        term = g[k*GROUP + j];
        for (int m = j + 1; m < GROUP; m++) begin
          term = term & p[k*GROUP + m];
        end
        gg[k] = gg[k] | term;
        gp[k] = gp[k] & p[k*GROUP + j];
      end
    end
    return {bb[WIDTH-1], av[WIDTH-1], ci, gp, gg, p, g, hs};
  endfunction

  // Second level: group carry-ins from group G/P, then in-group carries and sum.
  function automatic logic [RW-1:0] back_end(input logic [MW-1:0] mv);
    logic [WIDTH-1:0] hs;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] s;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic             ci;
    logic             am;
    logic             bm;
    logic             term;
    logic             carry;
    logic             ov;
    hs = mv[WIDTH-1:0];
    g  = mv[2*WIDTH-1:WIDTH];
    p  = mv[3*WIDTH-1:2*WIDTH];
    gg = mv[3*WIDTH+NG-1:3*WIDTH];
    gp = mv[3*WIDTH+2*NG-1:3*WIDTH+NG];
    ci = mv[MW-3];
    am = mv[MW-2];
    bm = mv[MW-1];
    // sum-of-products lookahead over groups; gc[NG] is the final carry out
    for (int k = 0; k <= NG; k++) begin
      term = ci;
      for (int j = 0; j < k; j++) begin
        term = term & gp[j];
      end
      gc[k] = term;
      for (int j = 0; j < k; j++) begin
        term = gg[j];
        for (int x = j + 1; x < k; x++) begin
          term = term & gp[x];
        end
        gc[k] = gc[k] | term;
      end
    end
    // sum-of-products lookahead inside each group from its carry-in
    for (int k = 0; k < NG; k++) begin
      for (int i = 0; i < GROUP; i++) begin
        carry = gc[k];
        for (int j = 0; j < i; j++) begin
          carry = carry & p[k*GROUP + j];
        end
        for (int j = 0; j < i; j++) begin
          term = g[k*GROUP + j];
          for (int x = j + 1; x < i; x++) begin
            term = term & p[k*GROUP + x];
          end
          carry = carry | term;
        end
        s[k*GROUP + i] = hs[k*GROUP + i] ^ carry;
      end
    end
    ov = (am == bm) && (s[WIDTH-1] != am);
    return {ov, gc[NG], s};
  endfunction

  logic              advance_s;
  logic [STAGES-1:0] vld_d;
  logic [STAGES-1:0] vld_q;
  logic [RW-1:0]     res_out_s;

  assign advance_s = out_ready | ~vld_q[STAGES-1];
  assign in_ready  = advance_s;
  assign out_valid = vld_q[STAGES-1];
  assign y         = res_out_s[WIDTH-1:0];
  assign cout      = res_out_s[WIDTH];
  assign ovf       = res_out_s[WIDTH+1];

  // Valid chain: shift one place on advance (bubbles carry 0), otherwise hold.
  always_comb begin
    vld_d = vld_q;
    if (advance_s) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end else begin
      vld_d = vld_q;
    end
  end

  // Valid chain register; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= {STAGES{1'b0}};
    end else begin
      vld_q <= vld_d;
    end
  end

  if (STAGES == 1) begin : g_one
    logic [RW-1:0] res_d;
    logic [RW-1:0] res_q;

    // Single stage: both lookahead levels ahead of the only register.
    always_comb begin
      res_d = res_q;
      if (advance_s) begin
        res_d = back_end(front_end(a, b, cin, sub));
      end else begin
        res_d = res_q;
      end
    end

    // Result register.
    always_ff @(posedge clk) begin
      if (rst) begin
        res_q <= {RW{1'b0}};
      end else begin
        res_q <= res_d;
      end
    end

    assign res_out_s = res_q;
  end else begin : g_multi
    logic [MW-1:0] mid_d;
    logic [MW-1:0] mid_q;
    logic [RW-1:0] res_d [1:STAGES-1];
    logic [RW-1:0] res_q [1:STAGES-1];

    // Stage 1 input: first-level terms from the operands.
    always_comb begin
      mid_d = mid_q;
      if (advance_s) begin
        mid_d = front_end(a, b, cin, sub);
      end else begin
        mid_d = mid_q;
      end
    end

    // Stage 2 input: second-level lookahead; later stages just shift results.
    always_comb begin
      for (int i = 1; i < STAGES; i++) begin
        res_d[i] = res_q[i];
      end
      if (advance_s) begin
        res_d[1] = back_end(mid_q);
        for (int i = 2; i < STAGES; i++) begin
          res_d[i] = res_q[i-1];
        end
      end else begin
        for (int i = 1; i < STAGES; i++) begin
          res_d[i] = res_q[i];
        end
      end
    end

    // Intermediate and result registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        mid_q <= {MW{1'b0}};
        for (int i = 1; i < STAGES; i++) begin
          res_q[i] <= {RW{1'b0}};
        end
      end else begin
        mid_q <= mid_d;
        for (int i = 1; i < STAGES; i++) begin
          res_q[i] <= res_d[i];
        end
      end
    end

    assign res_out_s = res_q[STAGES-1];
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: seven configurations run side by side
// (W16/G4/S2, W8/G4/S1..3, W32/G8/S1..3). Each has directed boundary
// vectors with a mid-stream stall, a one-cycle reset with ops in flight,
// and 10k random ops under random valid/ready, checked by a scoreboard.

module tb_cla_pipe_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;

  for (genvar k = 0; k < 7; k++) begin : g_cfg
    localparam int W = (k == 0) ? 16 : ((k < 4) ? 8 : 32);
    localparam int G = (k == 0) ? 4 : ((k < 4) ? 4 : 8);
    localparam int S = (k == 0) ? 2 : (((k - 1) % 3) + 1);

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         cout;
    logic         ovf;

    logic [W+1:0] qr[$];
    time          qt[$];
    int           qs[$];
    int           stall_cnt  = 0;
    int           stall_left = 0;
    bit           rnd_rdy    = 1'b0;
    logic         hold_chk   = 1'b0;
    logic [W+1:0] hold_val;

    cla_pipe_adder #(.WIDTH(W), .GROUP(G), .STAGES(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .cout      (cout),
      .ovf       (ovf)
    );

    // Reference: plain integer arithmetic, returns {ovf, cout, y}.
    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic cv, input logic sv);
      longint ua, ub, sa, sb, c, u, s, lim;
      logic [63:0] ubits;
      logic co, ov;
      lim = longint'(1) <<< (W - 1);
      ua = longint'(av);
      ub = longint'(bv);
      sa = (ua >= lim) ? ua - 2 * lim : ua;
      sb = (ub >= lim) ? ub - 2 * lim : ub;
      c  = cv ? longint'(1) : longint'(0);
      if (sv) begin
        u  = ua - ub - c;
        s  = sa - sb - c;
        co = (u >= 0);
      end else begin
        u  = ua + ub + c;
        s  = sa + sb + c;
        co = (u >= 2 * lim);
      end
      ov = (s < -lim) || (s >= lim);
      ubits = u;
      return {ov, co, ubits[W-1:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cfg%0d: got %0h want %0h", name, k, got, want);
      end
    endtask

    // Monitor: handshake rule, stall stability, in-order results and latency.
    always @(negedge clk) begin
      if (rst) begin
        hold_chk <= 1'b0;
      end else begin
        chk("in_ready", {63'd0, in_ready}, {63'd0, (out_ready || !out_valid)});
        if (!in_ready) stall_cnt <= stall_cnt + 1;
        if (hold_chk) chk("hold", {61'd0, out_valid, ovf, cout, y}, {61'd0, 1'b1, hold_val});
        hold_chk <= out_valid && !out_ready;
        hold_val <= {ovf, cout, y};
        if (out_valid && out_ready) begin
          if (qr.size() == 0) begin
            chk("unexpected_out", {63'd0, out_valid}, 64'd0);
          end else begin
            chk("result", {62'd0, ovf, cout, y}, {62'd0, qr[0]});
            chk("latency", $time, qt[0] + 64'(10 * (S + stall_cnt - qs[0])));
            qr.delete(0);
            qt.delete(0);
            qs.delete(0);
          end
        end
      end
    end

    // Consumer: forced stall windows, random ready, or always ready.
    initial begin
      out_ready = 1'b1;
      forever begin
        @(posedge clk);
        #1;
        if (stall_left > 0) begin
          out_ready  = 1'b0;
          stall_left = stall_left - 1;
        end else if (rnd_rdy) begin
          out_ready = ($urandom_range(0, 3) != 0);
        end else begin
          out_ready = 1'b1;
        end
      end
    end

    // Offer one op until accepted; record the expectation at acceptance.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input logic [W+1:0] ev);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
      while (!ok && n < 200) begin
        @(negedge clk);
        if (in_ready) begin
          qr.push_back(ev);
          qt.push_back($time);
          qs.push_back(stall_cnt);
          ok = 1'b1;
        end
        n++;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", {63'd0, ok}, 64'd1);
    endtask

    task automatic drain();
      for (int c = 0; c < 100 && qr.size() != 0; c++) @(posedge clk);
      #1;
      chk("drain", 64'(qr.size()), 64'd0);
    endtask

    task automatic chk_reset_state(input string name);
      chk(name, {60'd0, out_valid, in_ready, cout, ovf}, {60'd0, 4'b0100});
      chk("reset_y", {{(64-W){1'b0}}, y}, 64'd0);
    endtask

    // Stimulus: reset, directed vectors with a stall, reset with ops in flight, random.
    initial begin
      logic [W-1:0] ones, msb, smax, onesm1, v1, v2, v3, v5, v7, r;
      logic [31:0]  r32;
      logic [W-1:0] da[8];
      logic [W-1:0] db[8];
      logic         dc[8];
      logic         ds[8];
      logic [W+1:0] de[8];
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           sent;

      ones   = {W{1'b1}};
      msb    = {1'b1, {(W-1){1'b0}}};
      smax   = ~msb;
      onesm1 = {{(W-1){1'b1}}, 1'b0};
      v1 = {{(W-3){1'b0}}, 3'd1};
      v2 = {{(W-3){1'b0}}, 3'd2};
      v3 = {{(W-3){1'b0}}, 3'd3};
      v5 = {{(W-3){1'b0}}, 3'd5};
      v7 = {{(W-3){1'b0}}, 3'd7};

      // {ovf, cout, y} worked out by hand for each boundary case
      da[0] = ones; db[0] = v1;   dc[0] = 1'b0; ds[0] = 1'b0; de[0] = {2'b01, {W{1'b0}}};
      da[1] = v5;   db[1] = v7;   dc[1] = 1'b0; ds[1] = 1'b1; de[1] = {2'b00, onesm1};
      da[2] = msb;  db[2] = v1;   dc[2] = 1'b0; ds[2] = 1'b1; de[2] = {2'b11, smax};
      da[3] = smax; db[3] = v1;   dc[3] = 1'b0; ds[3] = 1'b0; de[3] = {2'b10, msb};
      da[4] = ones; db[4] = ones; dc[4] = 1'b1; ds[4] = 1'b0; de[4] = {2'b01, ones};
      da[5] = msb;  db[5] = msb;  dc[5] = 1'b0; ds[5] = 1'b1; de[5] = {2'b01, {W{1'b0}}};
      da[6] = v3;   db[6] = v3;   dc[6] = 1'b1; ds[6] = 1'b1; de[6] = {2'b00, ones};
      da[7] = {W{1'b0}}; db[7] = {W{1'b0}}; dc[7] = 1'b1; ds[7] = 1'b0; de[7] = {2'b00, v1};

      rst = 1'b1; in_valid = 1'b0; a = {W{1'b0}}; b = {W{1'b0}}; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_state("reset_hold");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // eight back-to-back ops, consumer stalls for 3 cycles mid-stream
      for (int i = 0; i < 8; i++) begin
        if (i == 3) stall_left = 3;
        send(da[i], db[i], dc[i], ds[i], de[i]);
      end
      drain();

      // one-cycle reset with two ops in flight; neither may ever appear
      send(v1, v2, 1'b0, 1'b0, {2'b00, v3});
      send(v7, v5, 1'b0, 1'b1, {2'b01, v2});
      rst = 1'b1;
      qr.delete();
      qt.delete();
      qs.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_state("reset_pulse");
      repeat (6) @(posedge clk);
      #1;

      // random ops with random bubbles and random back-pressure
      rnd_rdy = 1'b1;
      sent = 0;
      while (sent < 10000) begin
        if ($urandom_range(0, 9) < 3) begin
          @(posedge clk);
          #1;
        end else begin
          for (int j = 0; j < 2; j++) begin
            r32 = $urandom;
            case ($urandom_range(0, 7))
              0:       r = {W{1'b0}};
              1:       r = ones;
              2:       r = msb;
              3:       r = smax;
              default: r = r32[W-1:0];
            endcase
            if (j == 0) ra = r;
            else        rb = r;
          end
          rc = 1'($urandom_range(0, 1));
          rs = 1'($urandom_range(0, 1));
          send(ra, rb, rc, rs, model(ra, rb, rc, rs));
          sent++;
        end
      end
      rnd_rdy = 1'b0;
      drain();
      done_cnt++;
    end
  end

  // Wait for every configuration to finish, then report.
  initial begin
    for (int c = 0; c < 60000 && done_cnt < 7; c++) @(posedge clk);
    checks++;
    if (done_cnt != 7) begin
      errors++;
      $display("FAIL timeout: finished %0d configurations, want 7", done_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
